// File: rtl/ee465_rx_pkg.sv
// Shared receive-path definitions.
//  - DATA_W_DEF : default sample width (signed 1s17)
//  - fsm_state_e: phase-search FSM states
//  - abs_sat    : |x| of a w-bit signed value (sign-extended to 32 bits);
//                 the most negative code maps to the largest positive one.
package ee465_rx_pkg;

  localparam int DATA_W_DEF = 18;

  typedef enum logic [1:0] {IDLE, MEASURE, COMPARE, DONE} fsm_state_e;

  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (x == most_neg) return (32'd1 << (w - 1)) - 32'd1;
    else if (x < 0)    return $unsigned(-x);
    else               return $unsigned(x);
  endfunction

endpackage

// File: rtl/symbol_phase_aligner_abs_metric_acc.sv
// abs_metric_acc: accumulates |i|+|q| over SEARCH_SYMS symbols.
//  clk, rst_n : clock, async active-low reset
//  clr        : synchronous clear of sum and count (wins over en)
//  en         : add one metric sample and bump the count
//  in_i, in_q : signed samples
//  acc        : running sum, wide enough that SEARCH_SYMS full-scale adds never wrap
//  done       : count has reached SEARCH_SYMS (further en is ignored)
module abs_metric_acc
  import ee465_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SEARCH_SYMS = 1024,
  parameter int ACC_W       = DATA_W + 1 + $clog2(SEARCH_SYMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic [ACC_W-1:0]  acc,
  output logic              done
);

  localparam int CNT_W = $clog2(SEARCH_SYMS) + 1;

  logic [31:0]       abs_i, abs_q;
  logic [DATA_W-1:0] metric;
  logic [CNT_W-1:0]  cnt;

  // Each saturated magnitude is at most 2^(W-1)-1, so the sum fits W bits.
  always_comb begin
    abs_i  = abs_sat(32'($signed(in_i)), DATA_W);
    abs_q  = abs_sat(32'($signed(in_q)), DATA_W);
    metric = DATA_W'(abs_i + abs_q);
  end

  assign done = (cnt == CNT_W'(SEARCH_SYMS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en && !done) begin
      acc <= acc + ACC_W'(metric);
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/symbol_phase_aligner.sv
// symbol_phase_aligner: I/Q sample-to-symbol decimator with manual or
// searched sampling phase.
//  sys_clk, reset_n        : clock, async active-low reset
//  sam_clk_ena/sym_clk_ena : sample / symbol strobes (symbol coincides with a sample)
//  in_i, in_q              : matched-filter outputs, signed
//  mode_auto, manual_sel   : phase source select / manual tap index
//  start_search            : begin a phase search (auto mode only)
//  out_i, out_q, out_valid : symbol decisions, valid the cycle after the symbol strobe
//  sel_active              : tap currently feeding the outputs
//  search_busy/search_done : FSM not idle / result committed pulse
module symbol_phase_aligner
  import ee465_rx_pkg::*;
#(
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  MAX_DELAY   = 8,
  parameter int  SEARCH_SYMS = 1024,
  localparam int SEL_W       = $clog2(MAX_DELAY)
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              sam_clk_ena,
  input  logic              sym_clk_ena,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic              mode_auto,
  input  logic [SEL_W-1:0]  manual_sel,
  input  logic              start_search,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_valid,
  output logic [SEL_W-1:0]  sel_active,
  output logic              search_busy,
  output logic              search_done
);

  localparam int             NUM_LANES = 2;  // lane 0 = I, lane 1 = Q
  localparam int             ACC_W     = DATA_W + 1 + $clog2(SEARCH_SYMS);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_DELAY - 1);

  logic [NUM_LANES-1:0][DATA_W-1:0]                lane_in;
  logic [NUM_LANES-1:0][MAX_DELAY-1:0][DATA_W-1:0] tap;
  logic [0:0]                                      vld_pipe;

  fsm_state_e        state;
  logic [SEL_W-1:0]  cand, best_cand, best_sel;
  logic [ACC_W-1:0]  acc, best_metric;
  logic              acc_done, acc_clr, acc_en;

  assign lane_in = {in_q, in_i};

  // Delay lines: tap[k] is the input delayed k+1 sample strobes.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tap <= '0;
    end else if (sam_clk_ena) begin
      for (int l = 0; l < NUM_LANES; l++)
        tap[l] <= {tap[l][MAX_DELAY-2:0], lane_in[l]};
    end
  end

  // Output register reads pre-shift taps; sel_active only moves on a symbol
  // strobe so every emitted symbol comes from a single phase.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_i      <= '0;
      out_q      <= '0;
      sel_active <= '0;
      vld_pipe   <= '0;
    end else begin
      vld_pipe[0] <= sym_clk_ena;
      if (sym_clk_ena) begin
        out_i <= tap[0][sel_active];
        out_q <= tap[1][sel_active];
        if (mode_auto)                              sel_active <= best_sel;
        else if (int'(manual_sel) > MAX_DELAY - 1)  sel_active <= SEL_MAX;
        else                                        sel_active <= manual_sel;
      end
    end
  end

  assign out_valid = vld_pipe[0];

  // Single accumulator, candidate tap muxed in.
  assign acc_clr = (state == IDLE) || (state == COMPARE);
  assign acc_en  = (state == MEASURE) && sym_clk_ena;

  abs_metric_acc #(
    .DATA_W      (DATA_W),
    .SEARCH_SYMS (SEARCH_SYMS),
    .ACC_W       (ACC_W)
  ) u_acc (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .in_i  (tap[0][cand]),
    .in_q  (tap[1][cand]),
    .acc   (acc),
    .done  (acc_done)
  );

  // Search FSM. Dropping mode_auto anywhere in a search abandons it without
  // touching best_sel.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= '0;
      best_cand   <= '0;
      best_metric <= '0;
      best_sel    <= '0;
      search_done <= 1'b0;
    end else begin
      search_done <= 1'b0;
      if (state != IDLE && !mode_auto) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start_search && mode_auto) begin
            state       <= MEASURE;
            cand        <= '0;
            best_cand   <= '0;
            best_metric <= '0;
          end
          MEASURE: if (acc_done) state <= COMPARE;
          COMPARE: begin
            // Strict compare: ties keep the lower index.
            if (acc > best_metric) begin
              best_metric <= acc;
              best_cand   <= cand;
            end
            if (cand == SEL_MAX) begin
              state <= DONE;
            end else begin
              cand  <= cand + 1'b1;
              state <= MEASURE;
            end
          end
          DONE: begin
            best_sel    <= best_cand;
            search_done <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign search_busy = (state != IDLE);

endmodule

// File: tb/tb_symbol_phase_aligner.sv
module tb_symbol_phase_aligner;
  import ee465_rx_pkg::*;

  localparam int DW = 18;
  localparam int MD = 8;
  localparam int SS = 16;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic          sam_clk_ena, sym_clk_ena, mode_auto, start_search;
  logic [DW-1:0] in_i, in_q;
  logic [2:0]    manual_sel;
  logic [DW-1:0] out_i, out_q;
  logic          out_valid, search_busy, search_done;
  logic [2:0]    sel_active;
  // second instance with a non power-of-two depth for the clamp case
  logic [DW-1:0] o6_i, o6_q;
  logic          o6_v, o6_busy, o6_done;
  logic [2:0]    o6_sel;

  symbol_phase_aligner #(.DATA_W(DW), .MAX_DELAY(MD), .SEARCH_SYMS(SS)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
    .in_i(in_i), .in_q(in_q), .mode_auto(mode_auto), .manual_sel(manual_sel),
    .start_search(start_search), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .sel_active(sel_active), .search_busy(search_busy), .search_done(search_done));

  symbol_phase_aligner #(.DATA_W(DW), .MAX_DELAY(6), .SEARCH_SYMS(SS)) dut6 (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
    .in_i(in_i), .in_q(in_q), .mode_auto(mode_auto), .manual_sel(manual_sel),
    .start_search(start_search), .out_i(o6_i), .out_q(o6_q), .out_valid(o6_v),
    .sel_active(o6_sel), .search_busy(o6_busy), .search_done(o6_done));

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // scoreboard and reference delay line
  logic [DW-1:0] m_tap_i [MD];
  logic [DW-1:0] m_tap_q [MD];
  int            m_sel;
  logic [DW-1:0] exp_i [$];
  logic [DW-1:0] exp_q [$];
  bit            sb_en;

  // search observation
  int            sym_cnt, done_cnt, done_at;
  logic [2:0]    sel_at_done;
  logic [22:0]   acc_cap;
  bit            acc_cap_vld, busy_seen;

  function automatic logic [DW-1:0] ramp(input int t);
    return DW'(t * 97 + 100);
  endfunction

  task automatic reset_model();
    exp_i.delete(); exp_q.delete();
    for (int k = 0; k < MD; k++) begin m_tap_i[k] = '0; m_tap_q[k] = '0; end
    m_sel = 0;
  endtask

  // One sys_clk with the given strobes and data; returns 1 time unit after the edge.
  task automatic tick(input bit sam, input bit sym, input logic [DW-1:0] di, input logic [DW-1:0] dq);
    sam_clk_ena = sam; sym_clk_ena = sym; in_i = di; in_q = dq;
    if (sym) begin
      sym_cnt++;
      if (sb_en) begin
        exp_i.push_back(m_tap_i[m_sel]);
        exp_q.push_back(m_tap_q[m_sel]);
      end
      if (!mode_auto) m_sel = (int'(manual_sel) > MD - 1) ? MD - 1 : int'(manual_sel);
    end
    if (sam) begin
      for (int k = MD - 1; k > 0; k--) begin
        m_tap_i[k] = m_tap_i[k-1]; m_tap_q[k] = m_tap_q[k-1];
      end
      m_tap_i[0] = di; m_tap_q[0] = dq;
    end
    @(posedge sys_clk); #1;
    sam_clk_ena = 0; sym_clk_ena = 0; start_search = 0;
    if (search_done) begin done_cnt++; done_at = sym_cnt; sel_at_done = sel_active; end
    if (dut.state == COMPARE && !acc_cap_vld) begin acc_cap = dut.u_acc.acc; acc_cap_vld = 1; end
  endtask

  always @(negedge sys_clk) begin
    if (reset_n && out_valid && exp_i.size() > 0) begin
      logic [DW-1:0] ei, eq;
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (out_i !== ei || out_q !== eq) begin
        errors++;
        $display("FAIL sb_out: got i=%h q=%h expected i=%h q=%h", out_i, out_q, ei, eq);
      end
    end
  end

  // 8-sample symbol period, symbol strobe on the last sample. A pulse on
  // sample 1 sits in tap 5 at the strobe; cst drives every sample.
  task automatic run_period(input logic [DW-1:0] pi, input logic [DW-1:0] pq, input bit cst, input bit st);
    for (int p = 0; p < 8; p++) begin
      start_search = st && (p == 0);
      tick(1, p == 7, (cst || p == 1) ? pi : '0, (cst || p == 1) ? pq : '0);
    end
  endtask

  task automatic run_search(input logic [DW-1:0] pi, input logic [DW-1:0] pq, input bit cst);
    mode_auto = 1;
    run_period(pi, pq, cst, 0);
    sym_cnt = 0; done_cnt = 0; acc_cap_vld = 0;
    run_period(pi, pq, cst, 1);
    busy_seen = search_busy;
    for (int n = 0; n < 200 && done_cnt == 0; n++) run_period(pi, pq, cst, 0);
    run_period(pi, pq, cst, 0);
  endtask

  task automatic test_reset();
    reset_n = 0; mode_auto = 0; manual_sel = 2; start_search = 0;
    sam_clk_ena = 0; sym_clk_ena = 0; in_i = '0; in_q = '0;
    reset_model();
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1;
    sb_en = 1;
    for (int t = 0; t < 16; t++) tick(1, t % 4 == 3, ramp(t), ramp(t + 50));
    #2 reset_n = 0;
    #1;
    checks++;
    if ({out_i, out_q, sel_active, out_valid, search_busy, search_done} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got i=%h q=%h sel=%0d v=%b busy=%b done=%b expected all 0",
               out_i, out_q, sel_active, out_valid, search_busy, search_done);
    end
    reset_model();
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1;
    tick(1, 0, 18'd5, 18'd5);
    tick(1, 0, 18'd6, 18'd6);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_pre: got %b expected 0", out_valid); end
    tick(1, 1, 18'd7, 18'd7);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_valid_first: got %b expected 1", out_valid); end
    tick(1, 0, 18'd8, 18'd8);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_manual_impulse();
    manual_sel = 3;
    for (int t = 0; t < 8; t++) tick(1, t % 4 == 0, '0, '0);
    for (int t = 0; t < 20; t++) begin
      logic [DW-1:0] e;
      tick(1, t % 4 == 0, (t == 0) ? 18'h08000 : 18'h0, '0);
      if (t % 4 == 0) begin
        e = (t == 4) ? 18'h08000 : 18'h0;
        checks++;
        if (out_i !== e) begin errors++; $display("FAIL impulse_t%0d: got %h expected %h", t, out_i, e); end
      end
    end
    manual_sel = 7;
    tick(1, 1, '0, '0);
    checks++;
    if (sel_active !== 3'd7) begin errors++; $display("FAIL sel_7: got %0d expected 7", sel_active); end
    checks++;
    if (o6_sel !== 3'd5) begin errors++; $display("FAIL clamp_6: got %0d expected 5", o6_sel); end
  endtask

  task automatic test_coincident();
    manual_sel = 1;
    tick(1, 1, ramp(0), ~ramp(0));
    for (int t = 1; t <= 12; t++) begin
      tick(1, t % 3 == 0, ramp(t), ~ramp(t));
      if (t % 3 == 0) begin
        checks++;
        if (out_i !== ramp(t - 2)) begin
          errors++; $display("FAIL coincident_t%0d: got %h expected %h", t, out_i, ramp(t - 2));
        end
      end
    end
    tick(1, 0, '0, '0);
    sb_en = 0;
  endtask

  task automatic test_auto_search();
    run_search(18'h10000, 18'h30000, 0);
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL auto_busy: got %b expected 1", busy_seen); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL auto_done_cnt: got %0d expected 1", done_cnt); end
    checks++;
    if (done_at != MD * SS) begin errors++; $display("FAIL auto_done_syms: got %0d expected %0d", done_at, MD * SS); end
    checks++;
    if (sel_at_done !== 3'd0) begin errors++; $display("FAIL auto_sel_hold: got %0d expected 0", sel_at_done); end
    checks++;
    if (sel_active !== 3'd5) begin errors++; $display("FAIL auto_sel: got %0d expected 5", sel_active); end
    checks++;
    if (search_busy !== 1'b0) begin errors++; $display("FAIL auto_idle: got %b expected 0", search_busy); end
  endtask

  task automatic test_abort();
    mode_auto = 1;
    run_period(18'h10000, 18'h10000, 1, 1);
    for (int n = 0; n < 19; n++) run_period(18'h10000, 18'h10000, 1, 0);
    start_search = 1;
    tick(1, 0, 18'h10000, 18'h10000);
    checks++;
    if (dut.cand !== 3'd1) begin errors++; $display("FAIL ignore_cand: got %0d expected 1", dut.cand); end
    checks++;
    if (dut.u_acc.cnt !== 5'd4) begin errors++; $display("FAIL ignore_cnt: got %0d expected 4", dut.u_acc.cnt); end
    mode_auto = 0; manual_sel = 2; done_cnt = 0;
    tick(1, 0, '0, '0);
    checks++;
    if (search_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", search_busy); end
    for (int n = 0; n < 20; n++) run_period(18'h10000, 18'h10000, 1, 0);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    mode_auto = 1;
    run_period(18'h10000, 18'h10000, 1, 0);
    checks++;
    if (sel_active !== 3'd5) begin errors++; $display("FAIL abort_best: got %0d expected 5", sel_active); end
  endtask

  task automatic test_tie();
    run_search(18'h10000, 18'h10000, 1);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL tie_done: got %0d expected 1", done_cnt); end
    checks++;
    if (sel_active !== 3'd0) begin errors++; $display("FAIL tie_sel: got %0d expected 0", sel_active); end
    checks++;
    if (!acc_cap_vld || acc_cap !== 23'(SS * 2 * 65536)) begin
      errors++; $display("FAIL tie_acc: got %0d expected %0d", acc_cap, SS * 2 * 65536);
    end
  endtask

  task automatic test_saturate();
    run_search(18'h20000, 18'h20000, 1);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL sat_done: got %0d expected 1", done_cnt); end
    checks++;
    if (sel_active !== 3'd0) begin errors++; $display("FAIL sat_sel: got %0d expected 0", sel_active); end
    checks++;
    if (!acc_cap_vld || acc_cap !== 23'(SS * 2 * 131071)) begin
      errors++; $display("FAIL sat_acc: got %0d expected %0d", acc_cap, SS * 2 * 131071);
    end
  endtask

  initial begin
    test_reset();
    test_manual_impulse();
    test_coincident();
    test_auto_search();
    test_abort();
    test_tie();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
